operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter XLEN, default 32, data width of register values and write-back data.
REQ-002 Parameter CNT_W, default 16, width of the stall counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid / in_ready  input / output  1 / 1  decoded-instruction handshake; a transfer occurs when both are high.
REQ-006 in_rs1, in_rs2, in_rd  input  5 each  source and destination register indices.
REQ-007 in_rd_en  input  1  instruction writes in_rd.
REQ-008 rf_rs1_addr, rf_rs2_addr  output  5 each  register-file read addresses; the file registers them and returns data one cycle later.
REQ-009 rf_rs1_dout, rf_rs2_dout  input  XLEN each  register-file read data.
REQ-010 rf_we, rf_rd_addr, rf_rd_din  output  1, 5, XLEN  register-file write port.
REQ-011 wb_valid, wb_rd, wb_data  input  1, 5, XLEN  write-back request from execute.
REQ-012 out_valid / out_ready  output / input  1 / 1  operand handshake to execute.
REQ-013 out_rs1_val, out_rs2_val  output  XLEN each  fetched operands.
REQ-014 out_rd, out_rd_en  output  5, 1  destination passed downstream.
REQ-015 stall_cnt  output  CNT_W  count of hazard-stall cycles.

Function
REQ-016 The write port SHALL be combinational pass-through: rf_we = wb_valid AND wb_rd != 0, rf_rd_addr = wb_rd, rf_rd_din = wb_data.
REQ-017 The block SHALL hold a 32-bit pending scoreboard; bit 0 SHALL never be set.
REQ-018 A register r SHALL be "busy" when pending[r] = 1 AND NOT (wb_valid AND wb_rd = r).
- Same-cycle write-back SHALL clear the hazard.
- The register file returns the written value on the following cycle.
REQ-019 The block SHALL detect a hazard when in_valid is high and any of these holds:
- in_rs1 is busy;
- in_rs2 is busy;
- in_rd_en = 1 and in_rd != 0 and in_rd is busy (WAW).
REQ-020 in_ready SHALL be (NOT s1_valid OR out_ready) AND NOT hazard.
REQ-021 Stage S1 SHALL hold s1_valid, s1_rs1, s1_rs2, s1_rd and s1_rd_en.
REQ-022 On an input transfer, S1 SHALL load the instruction fields and s1_valid SHALL be set.
REQ-023 When S1 drains (out_valid AND out_ready) with no input transfer, s1_valid SHALL clear.
REQ-024 rf_rs1_addr / rf_rs2_addr SHALL be s1_rs1 / s1_rs2 when s1_valid = 1 AND out_ready = 0; otherwise they SHALL be in_rs1 / in_rs2.
- This keeps read data stable through back-pressure.
REQ-025 out_valid SHALL equal s1_valid.
REQ-026 out_rs1_val SHALL be 0 when s1_rs1 = 0, otherwise rf_rs1_dout; out_rs2_val SHALL follow the same rule using s1_rs2 and rf_rs2_dout.
REQ-027 out_rd SHALL equal s1_rd and out_rd_en SHALL equal s1_rd_en.
REQ-028 Latency: an instruction accepted in cycle t SHALL appear with out_valid = 1 in cycle t+1.
REQ-029 Throughput SHALL be one instruction per cycle when there is no hazard and out_ready = 1.
REQ-030 Scoreboard update order each edge:
- first, clear pending[wb_rd] if wb_valid;
- then, set pending[in_rd] on an input transfer with in_rd_en = 1 and in_rd != 0.
- When both target the same index, set SHALL win.
REQ-031 A write-back to a non-pending register SHALL still write the file and SHALL leave the scoreboard unchanged.
REQ-032 stall_cnt SHALL increment by 1 on each cycle where in_valid = 1 AND hazard = 1, and SHALL saturate at all-ones.
REQ-033 Output back-pressure alone SHALL NOT increment stall_cnt.

Reset
REQ-034 While rst_n = 0 the block SHALL asynchronously force s1_valid = 0, pending = 0 and stall_cnt = 0.
- Consequently out_valid = 0, and in_ready = 1 once rst_n rises.
REQ-035 A reset asserted mid-operation SHALL drop the S1 instruction and all pending entries.
REQ-036 Register-file contents SHALL NOT be touched by reset.
REQ-037 rf_we SHALL remain combinational from wb_valid during reset.

Verification
REQ-038 Back-to-back issue: issue add x3,x1,x2 (rd_en) then x5 <- x3.
- The second instruction is stalled (in_ready = 0, stall_cnt = 1 per cycle).
- Drive wb_valid, wb_rd = 3, wb_data = 0xDEADBEEF: the second instruction is accepted that cycle and out_rs1_val = 0xDEADBEEF next cycle.
REQ-039 x0 handling:
- in_rd = 0 with rd_en: no pending bit is set.
- in_rs1 = 0: out_rs1_val = 0.
- wb_rd = 0: rf_we = 0.
REQ-040 Back-pressure: hold out_ready = 0 for 5 cycles with S1 valid.
- in_ready = 0 throughout.
- out_rs1_val / out_rs2_val stay constant.
- stall_cnt does not change.
REQ-041 WAW: pending x7, then issue an instruction with rd = 7 and no source hazard; it stalls until wb_rd = 7, then issues and pending[7] stays 1.
REQ-042 Reset mid-stall: with pending[3] = 1 and S1 valid, pulse rst_n low.
- out_valid = 0 immediately.
- After release, an instruction reading x3 is accepted without stall.
REQ-043 Saturation: with CNT_W = 4, hold a hazard for 20 cycles; stall_cnt ends at 15.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand fetch stage: scoreboard-based hazard stall in front of a synchronous-read
// register file, with a single output register slice (S1) toward execute.
module operand_fetch #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [4:0]       in_rd,
    input  logic             in_rd_en,
    output logic [4:0]       rf_rs1_addr,
    output logic [4:0]       rf_rs2_addr,
    input  logic [XLEN-1:0]  rf_rs1_dout,
    input  logic [XLEN-1:0]  rf_rs2_dout,
    output logic             rf_we,
    output logic [4:0]       rf_rd_addr,
    output logic [XLEN-1:0]  rf_rd_din,
    input  logic             wb_valid,
    input  logic [4:0]       wb_rd,
    input  logic [XLEN-1:0]  wb_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_rs1_val,
    output logic [XLEN-1:0]  out_rs2_val,
    output logic [4:0]       out_rd,
    output logic             out_rd_en,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [31:0]      r_pending;
    logic             r_s1_valid;
    logic [4:0]       r_s1_rs1;
    logic [4:0]       r_s1_rs2;
    logic [4:0]       r_s1_rd;
    logic             r_s1_rd_en;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [31:0] w_wb_mask;
    logic [31:0] w_busy;
    logic [31:0] w_pending_nxt;
    logic        w_hazard;
    logic        w_in_xfer;
    logic        w_hold;

    assign rf_we      = wb_valid && (wb_rd != 5'd0);
    assign rf_rd_addr = wb_rd;
    assign rf_rd_din  = wb_data;

    // A write-back landing this cycle releases its register immediately.
    assign w_wb_mask = wb_valid ? (32'd1 << wb_rd) : 32'd0;
    assign w_busy    = r_pending & ~w_wb_mask;

    assign w_hazard  = in_valid && (w_busy[in_rs1] || w_busy[in_rs2] ||
                       (in_rd_en && (in_rd != 5'd0) && w_busy[in_rd]));
    assign in_ready  = (!r_s1_valid || out_ready) && !w_hazard;
    assign w_in_xfer = in_valid && in_ready;

    // Re-present the S1 addresses while stalled so the file's read data stays put.
    assign w_hold      = r_s1_valid && !out_ready;
    assign rf_rs1_addr = w_hold ? r_s1_rs1 : in_rs1;
    assign rf_rs2_addr = w_hold ? r_s1_rs2 : in_rs2;

    assign out_valid   = r_s1_valid;
    assign out_rs1_val = (r_s1_rs1 == 5'd0) ? '0 : rf_rs1_dout;
    assign out_rs2_val = (r_s1_rs2 == 5'd0) ? '0 : rf_rs2_dout;
    assign out_rd      = r_s1_rd;
    assign out_rd_en   = r_s1_rd_en;
    assign stall_cnt   = r_stall_cnt;

    always_comb begin
        w_pending_nxt = r_pending & ~w_wb_mask;
        if (w_in_xfer && in_rd_en && (in_rd != 5'd0))
            w_pending_nxt[in_rd] = 1'b1;
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_rs1    <= 5'd0;
            r_s1_rs2    <= 5'd0;
            r_s1_rd     <= 5'd0;
            r_s1_rd_en  <= 1'b0;
            r_pending   <= 32'd0;
            r_stall_cnt <= '0;
        end else begin
            if (w_in_xfer) begin
                r_s1_valid <= 1'b1;
                r_s1_rs1   <= in_rs1;
                r_s1_rs2   <= in_rs2;
                r_s1_rd    <= in_rd;
                r_s1_rd_en <= in_rd_en;
            end else if (out_ready) begin
                r_s1_valid <= 1'b0;
            end
            r_pending <= w_pending_nxt;
            if (w_hazard && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch with a behavioural synchronous-read register file.
module tb_operand_fetch;
    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_ready;
    logic [4:0]       in_rs1, in_rs2, in_rd;
    logic             in_rd_en;
    logic [4:0]       rf_rs1_addr, rf_rs2_addr;
    logic [XLEN-1:0]  rf_rs1_dout, rf_rs2_dout;
    logic             rf_we;
    logic [4:0]       rf_rd_addr;
    logic [XLEN-1:0]  rf_rd_din;
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             out_valid, out_ready;
    logic [XLEN-1:0]  out_rs1_val, out_rs2_val;
    logic [4:0]       out_rd;
    logic             out_rd_en;
    logic [CNT_W-1:0] stall_cnt;

    int errs = 0;
    int checks = 0;

    operand_fetch #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_en(in_rd_en),
        .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
        .rf_rs1_dout(rf_rs1_dout), .rf_rs2_dout(rf_rs2_dout),
        .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_rd_din(rf_rd_din),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_rd(out_rd), .out_rd_en(out_rd_en),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Register file: registered read address, write visible on the next read.
    logic [XLEN-1:0] mem [32];
    logic [4:0]      ra1, ra2;
    initial for (int i = 0; i < 32; i++) mem[i] = 32'h1000 + i;
    always @(posedge clk) begin
        ra1 <= rf_rs1_addr;
        ra2 <= rf_rs2_addr;
        if (rf_we) mem[rf_rd_addr] <= rf_rd_din;
    end
    assign rf_rs1_dout = mem[ra1];
    assign rf_rs2_dout = mem[ra2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] d, input logic de);
        in_valid = v; in_rs1 = s1; in_rs2 = s2; in_rd = d; in_rd_en = de;
    endtask

    task automatic wb(input logic v, input logic [4:0] r, input logic [31:0] d);
        wb_valid = v; wb_rd = r; wb_data = d;
    endtask

    initial begin
        rst_n = 1'b0; out_ready = 1'b1;
        issue(0, 0, 0, 0, 0);
        wb(0, 0, 0);
        #12;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_stall_cnt", 32'(stall_cnt), 0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 1);
        tick();

        // add x3,x1,x2 then x5 <- x3
        issue(1, 1, 2, 3, 1);
        #1 chk("b2b_first_ready", 32'(in_ready), 1);
        tick();
        chk("b2b_first_valid", 32'(out_valid), 1);
        chk("b2b_first_rs1", out_rs1_val, 32'h1001);
        chk("b2b_first_rs2", out_rs2_val, 32'h1002);
        chk("b2b_first_rd", 32'(out_rd), 3);
        issue(1, 3, 0, 5, 1);
        #1 chk("b2b_stall_ready", 32'(in_ready), 0);
        tick();
        chk("b2b_drained", 32'(out_valid), 0);
        chk("b2b_stall1", 32'(stall_cnt), 1);
        tick();
        chk("b2b_stall2", 32'(stall_cnt), 2);
        wb(1, 3, 32'hDEADBEEF);
        #1;
        chk("b2b_wb_we", 32'(rf_we), 1);
        chk("b2b_wb_ready", 32'(in_ready), 1);
        tick();
        wb(0, 0, 0); issue(0, 0, 0, 0, 0);
        chk("b2b_second_valid", 32'(out_valid), 1);
        chk("b2b_fwd_rs1", out_rs1_val, 32'hDEADBEEF);
        chk("b2b_second_rs2", out_rs2_val, 0);
        chk("b2b_second_rd", 32'(out_rd), 5);
        chk("b2b_stall_hold", 32'(stall_cnt), 2);

        // x0 handling
        issue(1, 0, 4, 0, 1);
        tick();
        chk("x0_rs1_zero", out_rs1_val, 0);
        chk("x0_rs2", out_rs2_val, 32'h1004);
        issue(1, 0, 0, 0, 1);
        wb(1, 0, 32'h1234);
        #1;
        chk("x0_not_pending", 32'(in_ready), 1);
        chk("x0_no_we", 32'(rf_we), 0);
        chk("wb_addr_pass", 32'(rf_rd_addr), 0);
        chk("wb_din_pass", rf_rd_din, 32'h1234);
        tick();
        issue(0, 0, 0, 0, 0);
        wb(1, 5, 32'h55);
        tick();
        // write-back to a register that was never pending
        wb(1, 10, 32'hA0A0);
        tick();
        wb(0, 0, 0);
        issue(1, 10, 5, 0, 0);
        #1 chk("nonpend_ready", 32'(in_ready), 1);
        tick();
        issue(0, 0, 0, 0, 0);
        chk("nonpend_data", out_rs1_val, 32'hA0A0);
        chk("x5_data", out_rs2_val, 32'h55);

        // back-pressure
        issue(1, 1, 2, 0, 0);
        tick();
        out_ready = 1'b0;
        issue(1, 6, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready", 32'(in_ready), 0);
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_rs1", out_rs1_val, 32'h1001);
            chk("bp_rs2", out_rs2_val, 32'h1002);
            chk("bp_stall_cnt", 32'(stall_cnt), 2);
            tick();
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(in_ready), 1);
        tick();
        issue(0, 0, 0, 0, 0);
        chk("bp_next_rs1", out_rs1_val, 32'h1006);

        // WAW on x7
        issue(1, 1, 2, 7, 1);
        tick();
        issue(1, 1, 2, 7, 1);
        #1 chk("waw_stall", 32'(in_ready), 0);
        tick();
        chk("waw_stall_cnt", 32'(stall_cnt), 3);
        wb(1, 7, 32'h77);
        #1 chk("waw_release", 32'(in_ready), 1);
        tick();
        wb(0, 0, 0);
        chk("waw_issued_rd", 32'(out_rd), 7);
        issue(1, 7, 0, 0, 0);
        #1 chk("waw_still_pending", 32'(in_ready), 0);
        issue(0, 0, 0, 0, 0);
        tick();

        // reset mid-stall
        issue(1, 1, 2, 3, 1);
        tick();
        issue(1, 3, 0, 0, 0);
        #1 chk("rst_mid_stall", 32'(in_ready), 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", 32'(out_valid), 0);
        chk("rst_mid_cnt", 32'(stall_cnt), 0);
        rst_n = 1'b1;
        #1 chk("rst_mid_accept", 32'(in_ready), 1);
        tick();
        issue(0, 0, 0, 0, 0);
        chk("rst_mid_out_valid", 32'(out_valid), 1);
        chk("rst_rf_kept", out_rs1_val, 32'hDEADBEEF);
        chk("rst_cnt_no_stall", 32'(stall_cnt), 0);

        // stall counter saturation
        issue(1, 0, 0, 9, 1);
        tick();
        issue(1, 9, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        chk("sat_mid", 32'(stall_cnt), 3);
        for (int i = 0; i < 17; i++) tick();
        chk("sat_end", 32'(stall_cnt), 15);
        chk("sat_ready", 32'(in_ready), 0);
        issue(0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
